ladybird_bus_ram_arb: RTL and testbench

- N-input bus arbiter fused with a single-port word RAM.
- Several bus primaries (e.g. an instruction-RAM loader and the core instruction port) share one on-chip memory.
- One transaction is accepted per cycle. The accepted requester receives a response one cycle later.
- Used as instruction/data memory in ladybird simulation and small-FPGA builds.

---
 rtl/ladybird_bus_ram_arb.sv | 117 +++++++++++
 tb/tb_ladybird_bus_ram_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ladybird_bus_ram_arb.sv
// rtl/ladybird_bus_ram_arb.sv - N-input arbiter fused with a single-port word RAM, one-cycle response.
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module ladybird_bus_ram_arb #(
    parameter int N_INPUT = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 3
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [N_INPUT-1:0]         req,
    input  logic [N_INPUT*32-1:0]      addr,
    input  logic [N_INPUT*DATA_W/8-1:0] wstrb,
    input  logic [N_INPUT*DATA_W-1:0]  wdata,
    output logic [N_INPUT-1:0]         gnt,
    output logic [N_INPUT-1:0]         rvalid,
    output logic [DATA_W-1:0]          rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;

    logic [DATA_W-1:0]  mem [2**ADDR_W];

    logic               found;
    logic [N_INPUT-1:0] sel_onehot;
    logic [ADDR_W-1:0]  sel_word;
    logic [NB-1:0]      sel_strb;
    logic [DATA_W-1:0]  sel_wdata;
    logic [DATA_W-1:0]  merged;
    logic               accept;

    // Only the word-index bits of each address matter; the rest alias.
    logic unused_addr;
    assign unused_addr = ^addr;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   sel_idx;

    // Pass 0 scans indices at or above the pointer, pass 1 wraps to those below.
    always_comb begin
        found      = 1'b0;
        sel_onehot = '0;
        sel_idx    = '0;
        sel_word   = '0;
        sel_strb   = '0;
        sel_wdata  = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < N_INPUT; i++) begin
                if (!found && req[i] && ((pass == 0) == (IDX_W'(i) >= rr_ptr))) begin
                    found         = 1'b1;
                    sel_onehot[i] = 1'b1;
                    sel_idx       = IDX_W'(i);
                    sel_word      = addr[32*i+2 +: ADDR_W];
                    sel_strb      = wstrb[NB*i +: NB];
                    sel_wdata     = wdata[DATA_W*i +: DATA_W];
                end
            end
        end
    end
`else
    always_comb begin
        found      = 1'b0;
        sel_onehot = '0;
        sel_word   = '0;
        sel_strb   = '0;
        sel_wdata  = '0;
        for (int i = 0; i < N_INPUT; i++) begin
            if (!found && req[i]) begin
                found         = 1'b1;
                sel_onehot[i] = 1'b1;
                sel_word      = addr[32*i+2 +: ADDR_W];
                sel_strb      = wstrb[NB*i +: NB];
                sel_wdata     = wdata[DATA_W*i +: DATA_W];
            end
        end
    end
`endif

    assign gnt    = arst ? '0 : sel_onehot;
    assign accept = |gnt;

    // Write-first: the response carries the word as it stands after the strobed merge.
    always_comb begin
        merged = mem[sel_word];
        for (int b = 0; b < NB; b++) begin
            if (sel_strb[b]) begin
                merged[8*b +: 8] = sel_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (|sel_strb)) begin
            mem[sel_word] <= merged;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rvalid <= '0;
            rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr <= '0;
`endif
        end else begin
            rvalid <= gnt;
            if (accept) begin
                rdata <= merged;
`ifdef ARB_ROUND_ROBIN_EN
                rr_ptr <= (sel_idx == IDX_W'(N_INPUT - 1)) ? '0 : sel_idx + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ladybird_bus_ram_arb.sv
// tb/tb_ladybird_bus_ram_arb.sv - directed scoreboard bench for ladybird_bus_ram_arb (N_INPUT=2).
module tb_ladybird_bus_ram_arb;

    logic        clk = 1'b0;
    logic        arst;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;

    ladybird_bus_ram_arb #(.N_INPUT(2), .DATA_W(32), .ADDR_W(3)) dut (
        .clk(clk), .arst(arst), .req(req), .addr(addr), .wstrb(wstrb),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mdl [8];
    int          mptr = 0;
    int          vectors = 0;
    int          errs = 0;
    logic [1:0]  last_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        req[p]          = r;
        addr[32*p +: 32] = a;
        wstrb[4*p +: 4]  = s;
        wdata[32*p +: 32] = d;
    endtask

    function automatic logic [1:0] model_gnt();
        if (req == 2'b00) return 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
        if (req == 2'b11) return (mptr == 1) ? 2'b10 : 2'b01;
        return req;
`else
        return req[0] ? 2'b01 : 2'b10;
`endif
    endfunction

    // One bus cycle: check the response due now, check the grant, push the expected response.
    task automatic step();
        logic [1:0]  eg;
        int          p;
        logic [2:0]  w;
        logic [31:0] word;
        rsp_t        it;
        @(negedge clk);
        if (q.size() > 0) begin
            it = q.pop_front();
            chk("rvalid", {30'b0, rvalid}, 32'(1 << it.port));
            chk("rdata", rdata, it.data);
        end else begin
            chk("rvalid_idle", {30'b0, rvalid}, 32'd0);
        end
        eg = model_gnt();
        last_gnt = gnt;
        chk("gnt", {30'b0, gnt}, {30'b0, eg});
        if (eg != 2'b00) begin
            p    = eg[1] ? 1 : 0;
            w    = addr[32*p+2 +: 3];
            word = mdl[w];
            for (int b = 0; b < 4; b++)
                if (wstrb[4*p+b]) word[8*b +: 8] = wdata[32*p+8*b +: 8];
            if (wstrb[4*p +: 4] != 4'b0) mdl[w] = word;
            it.port = p;
            it.data = word;
            q.push_back(it);
            mptr = (p + 1) % 2;
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] prog [5];
    logic [1:0]  cont_exp [4];

    initial begin
        prog[0] = 32'h000000B7; prog[1] = 32'h0000A103; prog[2] = 32'h00110113;
        prog[3] = 32'h0020A023; prog[4] = 32'hFF5FF0EF;
`ifdef ARB_ROUND_ROBIN_EN
        cont_exp[0] = 2'b01; cont_exp[1] = 2'b10; cont_exp[2] = 2'b01; cont_exp[3] = 2'b10;
`else
        cont_exp[0] = 2'b01; cont_exp[1] = 2'b01; cont_exp[2] = 2'b01; cont_exp[3] = 2'b01;
`endif
        arst = 1'b1; req = '0; addr = '0; wstrb = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", {30'b0, gnt}, 32'd0);
        chk("reset_rvalid", {30'b0, rvalid}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        arst = 1'b0;

        // Loader writes, then core port reads back
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 32'(4*i), 4'hF, prog[i]);
            step();
        end
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'b1, 32'(4*i), 4'h0, 32'h0);
            step();
        end
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        step();

        // Byte strobes
        drive(0, 1'b1, 32'h4, 4'hF, 32'h11223344); step();
        drive(0, 1'b1, 32'h4, 4'h2, 32'hAABBCCDD); step();
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h4, 4'h0, 32'h0); step();
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0); step();
        chk("strobe_merge", rdata, 32'h1122CC44);

        // Address wrap and ignored low bits
        drive(0, 1'b1, 32'h0, 4'hF, 32'hDEADBEEF); step();
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h20, 4'h0, 32'h0); step();
        drive(1, 1'b1, 32'hFFFFF000, 4'h0, 32'h0); step();
        drive(1, 1'b1, 32'h2, 4'h0, 32'h0); step();
        drive(1, 1'b1, 32'h3, 4'h0, 32'h0); step();
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0); step();
        chk("wrap_read", rdata, 32'hDEADBEEF);

        // Contention: both ports request for four cycles
        drive(0, 1'b1, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h4, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("contention_gnt", {30'b0, last_gnt}, {30'b0, cont_exp[i]});
        end
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        step();

        // Read immediately after write to the same word
        drive(0, 1'b1, 32'h8, 4'hF, 32'h5A5A5A5A); step();
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h8, 4'h0, 32'h0); step();
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0); step();
        chk("raw_read", rdata, 32'h5A5A5A5A);

        // Reset between acceptance and response of a read
        drive(1, 1'b1, 32'h8, 4'h0, 32'h0); step();
        arst = 1'b1;
        #1;
        chk("rst_rvalid_async", {30'b0, rvalid}, 32'd0);
        chk("rst_rdata_async", rdata, 32'd0);
        chk("rst_gnt", {30'b0, gnt}, 32'd0);
        q.delete();
        mptr = 0;
        @(negedge clk);
        chk("rst_gnt_held", {30'b0, gnt}, 32'd0);
        chk("rst_rvalid_held", {30'b0, rvalid}, 32'd0);
        @(posedge clk); #1;
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
        arst = 1'b0;
        step();
        drive(1, 1'b1, 32'h8, 4'h0, 32'h0); step();
        drive(1, 1'b1, 32'h0, 4'h0, 32'h0); step();
        drive(1, 1'b1, 32'h10, 4'h0, 32'h0); step();
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0); step();
        chk("post_reset_read", rdata, 32'hFF5FF0EF);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
